// File: rtl/ex_stage_pkg.sv
// Shared constants for the execute stage: ALU opcodes, forwarding selects,
// divider FSM states and a small opcode-classification helper.
package ex_stage_pkg;

    // ALU / compare / divide operation codes carried on alu_op
    localparam logic [5:0] ALU_NOP   = 6'd0;
    localparam logic [5:0] ALU_ADD   = 6'd1;
    localparam logic [5:0] ALU_SUB   = 6'd2;
    localparam logic [5:0] ALU_SLL   = 6'd3;
    localparam logic [5:0] ALU_SLT   = 6'd4;
    localparam logic [5:0] ALU_SLTU  = 6'd5;
    localparam logic [5:0] ALU_XOR   = 6'd6;
    localparam logic [5:0] ALU_SRL   = 6'd7;
    localparam logic [5:0] ALU_SRA   = 6'd8;
    localparam logic [5:0] ALU_OR    = 6'd9;
    localparam logic [5:0] ALU_AND   = 6'd10;
    localparam logic [5:0] ALU_PASSB = 6'd11;
    localparam logic [5:0] ALU_BEQ   = 6'd16;
    localparam logic [5:0] ALU_BNE   = 6'd17;
    localparam logic [5:0] ALU_BLT   = 6'd18;
    localparam logic [5:0] ALU_BGE   = 6'd19;
    localparam logic [5:0] ALU_BLTU  = 6'd20;
    localparam logic [5:0] ALU_BGEU  = 6'd21;
    localparam logic [5:0] ALU_DIV   = 6'd32;
    localparam logic [5:0] ALU_DIVU  = 6'd33;
    localparam logic [5:0] ALU_REM   = 6'd34;
    localparam logic [5:0] ALU_REMU  = 6'd35;

    // Forwarding select encodings (anything else reads the register file)
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // Iterative divider states
    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

    function automatic logic is_div_op(input logic [5:0] op);
        return (op == ALU_DIV) || (op == ALU_DIVU) || (op == ALU_REM) || (op == ALU_REMU);
    endfunction

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX fields, bypass values and EX/MEM results of the execute stage,
// bundled so the pipeline-side driver and the stage share one connection.
interface ex_stage_if #(
    parameter int XLEN = 32
);
    // ID/EX pipeline register fields
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rd_addr;
    logic [5:0]      alu_op;
    logic            alu_src_a;
    logic            alu_src_b;
    logic            mem_read;
    logic            mem_write;
    logic            mem_to_reg;
    logic            reg_write;
    logic            branch;
    logic            jump;
    // Bypass network and kill
    logic [XLEN-1:0] forward_mem_data;
    logic [XLEN-1:0] forward_wb_data;
    logic [1:0]      forward_a_sel;
    logic [1:0]      forward_b_sel;
    logic            flush;
    // Stage results
    logic            ex_busy;
    logic            branch_taken;
    logic [XLEN-1:0] branch_target;
    logic [XLEN-1:0] alu_result_out;
    logic [XLEN-1:0] store_data_out;
    logic [4:0]      rd_addr_out;
    logic            mem_read_out;
    logic            mem_write_out;
    logic            mem_to_reg_out;
    logic            reg_write_out;

    modport master (
        output pc, pc_plus4, rs1_data, rs2_data, imm, rd_addr, alu_op,
               alu_src_a, alu_src_b, mem_read, mem_write, mem_to_reg,
               reg_write, branch, jump, forward_mem_data, forward_wb_data,
               forward_a_sel, forward_b_sel, flush,
        input  ex_busy, branch_taken, branch_target, alu_result_out,
               store_data_out, rd_addr_out, mem_read_out, mem_write_out,
               mem_to_reg_out, reg_write_out
    );

    modport slave (
        input  pc, pc_plus4, rs1_data, rs2_data, imm, rd_addr, alu_op,
               alu_src_a, alu_src_b, mem_read, mem_write, mem_to_reg,
               reg_write, branch, jump, forward_mem_data, forward_wb_data,
               forward_a_sel, forward_b_sel, flush,
        output ex_busy, branch_taken, branch_target, alu_result_out,
               store_data_out, rd_addr_out, mem_read_out, mem_write_out,
               mem_to_reg_out, reg_write_out
    );
endinterface

// File: rtl/ex_divider.sv
// Iterative restoring divider: one quotient bit per cycle on magnitudes,
// sign fixup and RISC-V divide-by-zero / overflow results applied at DONE.
module ex_divider
    import ex_stage_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int DIV_CYCLES = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            flush,
    input  logic            is_signed,
    input  logic            want_rem,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(DIV_CYCLES);
    localparam logic [CW-1:0] LAST_STEP = CW'(DIV_CYCLES - 1);

    div_state_t      state_reg;
    logic [CW-1:0]   count_reg;
    logic [XLEN-1:0] quot_reg;
    logic [XLEN-1:0] rem_reg;
    logic [XLEN-1:0] divisor_reg;
    logic [XLEN-1:0] dividend_reg;
    logic            neg_q_reg;
    logic            neg_r_reg;
    logic            div_zero_reg;
    logic            want_rem_reg;

    logic [XLEN:0]   shifted;
    logic [XLEN:0]   diff;
    logic [XLEN-1:0] quot_next;
    logic [XLEN-1:0] rem_next;
    logic [XLEN-1:0] q_fix;
    logic [XLEN-1:0] r_fix;

    // Busy is raised in the same cycle a divide arrives so the front end stalls at once
    assign busy = (state_reg == DIV_RUN) || ((state_reg == DIV_IDLE) && start && !flush);
    assign done = (state_reg == DIV_DONE);

    // One restoring step: shift in the next dividend bit, subtract if it fits
    always_comb begin
        shifted   = {rem_reg, quot_reg[XLEN-1]};
        diff      = shifted - {1'b0, divisor_reg};
        quot_next = {quot_reg[XLEN-2:0], 1'b0};
        rem_next  = shifted[XLEN-1:0];
        if (!diff[XLEN]) begin
            quot_next[0] = 1'b1;
            rem_next     = diff[XLEN-1:0];
        end
    end

    // Final result: magnitudes get their signs back; divide-by-zero is special-cased
    always_comb begin
        q_fix = neg_q_reg ? (~quot_reg + 1'b1) : quot_reg;
        r_fix = neg_r_reg ? (~rem_reg + 1'b1) : rem_reg;
        if (div_zero_reg) begin
            q_fix = '1;
            r_fix = dividend_reg;
        end
        result = want_rem_reg ? r_fix : q_fix;
    end

    // Divider FSM: latch operands in IDLE, iterate in RUN, present result in DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= DIV_IDLE;
            count_reg    <= '0;
            quot_reg     <= '0;
            rem_reg      <= '0;
            divisor_reg  <= '0;
            dividend_reg <= '0;
            neg_q_reg    <= 1'b0;
            neg_r_reg    <= 1'b0;
            div_zero_reg <= 1'b0;
            want_rem_reg <= 1'b0;
        end else if (flush) begin
            state_reg <= DIV_IDLE;
            count_reg <= '0;
        end else begin
            case (state_reg)
                DIV_IDLE: begin
                    if (start) begin
                        quot_reg     <= (is_signed && dividend[XLEN-1]) ? (~dividend + 1'b1) : dividend;
                        divisor_reg  <= (is_signed && divisor[XLEN-1]) ? (~divisor + 1'b1) : divisor;
                        rem_reg      <= '0;
                        dividend_reg <= dividend;
                        neg_q_reg    <= is_signed && (dividend[XLEN-1] ^ divisor[XLEN-1]);
                        neg_r_reg    <= is_signed && dividend[XLEN-1];
                        div_zero_reg <= (divisor == '0);
                        want_rem_reg <= want_rem;
                        count_reg    <= '0;
                        state_reg    <= DIV_RUN;
                    end
                end
                DIV_RUN: begin
                    quot_reg  <= quot_next;
                    rem_reg   <= rem_next;
                    count_reg <= count_reg + CW'(1);
                    if (count_reg == LAST_STEP) begin
                        state_reg <= DIV_DONE;
                    end
                end
                DIV_DONE: begin
                    state_reg <= DIV_IDLE;
                end
                default: begin
                    state_reg <= DIV_IDLE;
                end
            endcase
        end
    end
endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, branch/jump resolution and the
// EX/MEM pipeline register; divides run in the iterative ex_divider.
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int DIV_CYCLES = 32
) (
    input logic        clk,
    input logic        rst_n,
    ex_stage_if.slave  bus
);
    localparam int SHW = $clog2(XLEN);

    logic [XLEN-1:0] fwd_a;
    logic [XLEN-1:0] fwd_b;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] ex_result;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] jalr_sum;
    logic            cmp_true;
    logic            div_start;
    logic            div_signed;
    logic            div_rem;
    logic            div_busy;
    logic            div_done;
    logic [XLEN-1:0] div_result;

    logic [XLEN-1:0] alu_result_reg;
    logic [XLEN-1:0] store_data_reg;
    logic [4:0]      rd_addr_reg;
    logic            mem_read_reg;
    logic            mem_write_reg;
    logic            mem_to_reg_reg;
    logic            reg_write_reg;

    // Bypass muxes: MEM beats WB beats register file
    always_comb begin
        case (bus.forward_a_sel)
            FWD_MEM: fwd_a = bus.forward_mem_data;
            FWD_WB:  fwd_a = bus.forward_wb_data;
            default: fwd_a = bus.rs1_data;
        endcase
        case (bus.forward_b_sel)
            FWD_MEM: fwd_b = bus.forward_mem_data;
            FWD_WB:  fwd_b = bus.forward_wb_data;
            default: fwd_b = bus.rs2_data;
        endcase
    end

    assign op_a  = bus.alu_src_a ? bus.pc : fwd_a;
    assign op_b  = bus.alu_src_b ? bus.imm : fwd_b;
    assign shamt = op_b[SHW-1:0];

    // Single-cycle ALU; compare, divide and unknown codes yield zero here
    always_comb begin
        alu_result = '0;
        case (bus.alu_op)
            ALU_NOP:   alu_result = '0;
            ALU_ADD:   alu_result = op_a + op_b;
            ALU_SUB:   alu_result = op_a - op_b;
            ALU_SLL:   alu_result = op_a << shamt;
            ALU_SLT:   alu_result = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            ALU_SLTU:  alu_result = {{(XLEN-1){1'b0}}, (op_a < op_b)};
            ALU_XOR:   alu_result = op_a ^ op_b;
            ALU_SRL:   alu_result = op_a >> shamt;
            ALU_SRA:   alu_result = $signed(op_a) >>> shamt;
            ALU_OR:    alu_result = op_a | op_b;
            ALU_AND:   alu_result = op_a & op_b;
            ALU_PASSB: alu_result = op_b;
            default:   alu_result = '0;
        endcase
    end

    // Branch condition on the forwarded register operands
    always_comb begin
        cmp_true = 1'b0;
        case (bus.alu_op)
            ALU_BEQ:  cmp_true = (fwd_a == fwd_b);
            ALU_BNE:  cmp_true = (fwd_a != fwd_b);
            ALU_BLT:  cmp_true = ($signed(fwd_a) <  $signed(fwd_b));
            ALU_BGE:  cmp_true = ($signed(fwd_a) >= $signed(fwd_b));
            ALU_BLTU: cmp_true = (fwd_a <  fwd_b);
            ALU_BGEU: cmp_true = (fwd_a >= fwd_b);
            default:  cmp_true = 1'b0;
        endcase
    end

    // Redirect target: JALR is register-relative with bit 0 cleared, others PC-relative
    always_comb begin
        jalr_sum = fwd_a + bus.imm;
        if (bus.jump && !bus.alu_src_a) begin
            target = {jalr_sum[XLEN-1:1], 1'b0};
        end else begin
            target = bus.pc + bus.imm;
        end
    end

    assign div_start  = is_div_op(bus.alu_op);
    assign div_signed = (bus.alu_op == ALU_DIV) || (bus.alu_op == ALU_REM);
    assign div_rem    = (bus.alu_op == ALU_REM) || (bus.alu_op == ALU_REMU);

    ex_divider #(
        .XLEN       (XLEN),
        .DIV_CYCLES (DIV_CYCLES)
    ) u_divider (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (div_start),
        .flush     (bus.flush),
        .is_signed (div_signed),
        .want_rem  (div_rem),
        .dividend  (fwd_a),
        .divisor   (fwd_b),
        .busy      (div_busy),
        .done      (div_done),
        .result    (div_result)
    );

    assign bus.ex_busy       = div_busy;
    assign bus.branch_taken  = ((bus.branch && cmp_true) || bus.jump) && !div_busy && !bus.flush;
    assign bus.branch_target = target;

    // Value written to EX/MEM: divider result, link address for jumps, else ALU
    always_comb begin
        if (div_done) begin
            ex_result = div_result;
        end else if (bus.jump) begin
            ex_result = bus.pc_plus4;
        end else begin
            ex_result = alu_result;
        end
    end

    // EX/MEM register: bubble on flush or while the divider holds EX
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_result_reg <= '0;
            store_data_reg <= '0;
            rd_addr_reg    <= '0;
            mem_read_reg   <= 1'b0;
            mem_write_reg  <= 1'b0;
            mem_to_reg_reg <= 1'b0;
            reg_write_reg  <= 1'b0;
        end else if (bus.flush || div_busy) begin
            alu_result_reg <= '0;
            store_data_reg <= '0;
            rd_addr_reg    <= '0;
            mem_read_reg   <= 1'b0;
            mem_write_reg  <= 1'b0;
            mem_to_reg_reg <= 1'b0;
            reg_write_reg  <= 1'b0;
        end else begin
            alu_result_reg <= ex_result;
            store_data_reg <= fwd_b;
            rd_addr_reg    <= bus.rd_addr;
            mem_read_reg   <= bus.mem_read;
            mem_write_reg  <= bus.mem_write;
            mem_to_reg_reg <= bus.mem_to_reg;
            reg_write_reg  <= bus.reg_write;
        end
    end

    assign bus.alu_result_out = alu_result_reg;
    assign bus.store_data_out = store_data_reg;
    assign bus.rd_addr_out    = rd_addr_reg;
    assign bus.mem_read_out   = mem_read_reg;
    assign bus.mem_write_out  = mem_write_reg;
    assign bus.mem_to_reg_out = mem_to_reg_reg;
    assign bus.reg_write_out  = reg_write_reg;
endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: a vector table for single-cycle ops and
// branches, hand-written sequences for divides, flush and mid-divide reset.
module tb_ex_stage;
    import ex_stage_pkg::*;

    logic clk;
    logic rst_n;

    ex_stage_if #(.XLEN(32)) bus ();

    ex_stage #(
        .XLEN       (32),
        .DIV_CYCLES (32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [31:0] MEM_VAL = 32'd5;
    localparam logic [31:0] WB_VAL  = 32'h20;

    typedef struct {
        string       name;
        logic [5:0]  op;
        logic [31:0] rs1, rs2, imm, pc;
        logic [1:0]  fa, fb;
        logic        sa, sb, br, jmp, fl, mr, mw, m2r, rw;
        logic [31:0] exp_res, exp_store;
        logic        exp_taken;
        logic [31:0] exp_target;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] res;
        logic [31:0] store;
        logic [8:0]  ctrl;   // {rd, mem_read, mem_write, mem_to_reg, reg_write}
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    function automatic vec_t mk(string n, logic [5:0] op, logic [31:0] rs1, logic [31:0] rs2,
                                logic [31:0] imm, logic [31:0] pc, logic [1:0] fa, logic [1:0] fb,
                                logic sa, logic sb, logic br, logic jmp, logic fl,
                                logic [31:0] er, logic [31:0] es, logic et, logic [31:0] etg);
        vec_t v;
        v.name = n; v.op = op; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm; v.pc = pc;
        v.fa = fa; v.fb = fb; v.sa = sa; v.sb = sb; v.br = br; v.jmp = jmp; v.fl = fl;
        v.mr = 1'b0; v.mw = 1'b0; v.m2r = 1'b0; v.rw = ~br;
        v.exp_res = er; v.exp_store = es; v.exp_taken = et; v.exp_target = etg;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.pc = '0; bus.pc_plus4 = 32'd4; bus.rs1_data = '0; bus.rs2_data = '0; bus.imm = '0;
        bus.rd_addr = '0; bus.alu_op = ALU_NOP; bus.alu_src_a = 1'b0; bus.alu_src_b = 1'b0;
        bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.mem_to_reg = 1'b0; bus.reg_write = 1'b0;
        bus.branch = 1'b0; bus.jump = 1'b0; bus.forward_mem_data = MEM_VAL;
        bus.forward_wb_data = WB_VAL; bus.forward_a_sel = 2'b00; bus.forward_b_sel = 2'b00;
        bus.flush = 1'b0;
    endtask

    task automatic push_exp(string n, logic [31:0] res, logic [31:0] store, logic [8:0] ctrl);
        exp_t e;
        e.name = n; e.res = res; e.store = store; e.ctrl = ctrl;
        exp_q.push_back(e);
    endtask

    // Clock edge, then pop the scoreboard and compare the EX/MEM register
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty: got no expectation required one");
        end else begin
            e = exp_q.pop_front();
            chk({e.name, "_result"}, bus.alu_result_out, e.res);
            chk({e.name, "_store"}, bus.store_data_out, e.store);
            chk({e.name, "_ctrl"}, 32'({bus.rd_addr_out, bus.mem_read_out, bus.mem_write_out,
                                        bus.mem_to_reg_out, bus.reg_write_out}), 32'(e.ctrl));
        end
    endtask

    task automatic drive_div(logic [5:0] op, logic [31:0] a, logic [31:0] b);
        clear_inputs();
        bus.alu_op = op; bus.rs1_data = a; bus.rs2_data = b;
        bus.rd_addr = 5'd9; bus.reg_write = 1'b1;
    endtask

    // Full divide: 33 busy cycles with bubbles, then the result on the 34th edge
    task automatic run_div(string n, logic [5:0] op, logic [31:0] a, logic [31:0] b,
                           logic [31:0] exp, logic scramble);
        drive_div(op, a, b);
        for (int c = 0; c <= 33; c++) begin
            #4;
            chk($sformatf("%s_busy_c%0d", n, c), 32'(bus.ex_busy), 32'(c < 33));
            if (c < 33) push_exp({n, "_bubble"}, '0, '0, 9'd0);
            else        push_exp(n, exp, b, {5'd9, 4'b0001});
            if (scramble && c == 2) begin
                bus.rs1_data = $urandom; bus.rs2_data = $urandom;
                bus.forward_a_sel = FWD_MEM; bus.forward_b_sel = FWD_WB;
            end
            if (scramble && c == 30) begin
                bus.rs1_data = a; bus.rs2_data = b;
                bus.forward_a_sel = 2'b00; bus.forward_b_sel = 2'b00;
            end
            tick();
        end
        $display("txn %s a=%h b=%h result=%h", n, a, b, bus.alu_result_out);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        clear_inputs();
        rst_n = 1'b0;

        vecs.push_back(mk("add_fwd_mem", ALU_ADD,  32'd99, 32'd7, 0, 0, FWD_MEM, 2'b00, 0,0,0,0,0, 32'd12, 32'd7, 0, 0));
        vecs.push_back(mk("sub",         ALU_SUB,  32'd10, 32'd3, 0, 0, 2'b00, 2'b00, 0,0,0,0,0, 32'd7, 32'd3, 0, 0));
        vecs.push_back(mk("sll_imm",     ALU_SLL,  32'd1, 32'd0, 32'h24, 0, 2'b00, 2'b00, 0,1,0,0,0, 32'd16, 32'd0, 0, 0));
        vecs.push_back(mk("slt",         ALU_SLT,  32'hFFFFFFFF, 32'd1, 0, 0, 2'b00, 2'b00, 0,0,0,0,0, 32'd1, 32'd1, 0, 0));
        vecs.push_back(mk("sltu",        ALU_SLTU, 32'hFFFFFFFF, 32'd1, 0, 0, 2'b00, 2'b00, 0,0,0,0,0, 32'd0, 32'd1, 0, 0));
        vecs.push_back(mk("xor",         ALU_XOR,  32'hF0F0, 32'h0FF0, 0, 0, 2'b00, 2'b00, 0,0,0,0,0, 32'hFF00, 32'h0FF0, 0, 0));
        vecs.push_back(mk("srl",         ALU_SRL,  32'h80000000, 32'd4, 0, 0, 2'b00, 2'b00, 0,0,0,0,0, 32'h08000000, 32'd4, 0, 0));
        vecs.push_back(mk("sra",         ALU_SRA,  32'h80000000, 32'd4, 0, 0, 2'b00, 2'b00, 0,0,0,0,0, 32'hF8000000, 32'd4, 0, 0));
        vecs.push_back(mk("or",          ALU_OR,   32'hF0, 32'h0F, 0, 0, 2'b00, 2'b00, 0,0,0,0,0, 32'hFF, 32'h0F, 0, 0));
        vecs.push_back(mk("and",         ALU_AND,  32'hF0, 32'h3C, 0, 0, 2'b00, 2'b00, 0,0,0,0,0, 32'h30, 32'h3C, 0, 0));
        vecs.push_back(mk("lui",         ALU_PASSB, 32'd0, 32'd0, 32'h12345000, 0, 2'b00, 2'b00, 0,1,0,0,0, 32'h12345000, 32'd0, 0, 0));
        vecs.push_back(mk("auipc",       ALU_ADD,  32'd0, 32'd0, 32'h1000, 32'h100, 2'b00, 2'b00, 1,1,0,0,0, 32'h1100, 32'd0, 0, 0));
        vecs.push_back(mk("sub_fwd_wb",  ALU_SUB,  32'h30, 32'd1, 0, 0, 2'b00, FWD_WB, 0,0,0,0,0, 32'h10, 32'h20, 0, 0));
        vecs.push_back(mk("sel11_reg",   ALU_ADD,  32'd3, 32'd4, 0, 0, 2'b11, 2'b11, 0,0,0,0,0, 32'd7, 32'd4, 0, 0));
        vecs.push_back(mk("blt_taken",   ALU_BLT,  32'hFFFFFFFF, 32'd1, 32'h20, 32'h100, 2'b00, 2'b00, 0,0,1,0,0, 32'd0, 32'd1, 1, 32'h120));
        vecs.push_back(mk("blt_not",     ALU_BLT,  32'd2, 32'd1, 32'h20, 32'h100, 2'b00, 2'b00, 0,0,1,0,0, 32'd0, 32'd1, 0, 0));
        vecs.push_back(mk("beq_fwd",     ALU_BEQ,  32'd5, 32'd9, 32'hFFFFFFF8, 32'h40, 2'b00, FWD_MEM, 0,0,1,0,0, 32'd0, 32'd5, 1, 32'h38));
        vecs.push_back(mk("bne_eq",      ALU_BNE,  32'd7, 32'd7, 32'h8, 32'h40, 2'b00, 2'b00, 0,0,1,0,0, 32'd0, 32'd7, 0, 0));
        vecs.push_back(mk("bge_not",     ALU_BGE,  32'hFFFFFFFF, 32'd1, 32'h8, 32'h40, 2'b00, 2'b00, 0,0,1,0,0, 32'd0, 32'd1, 0, 0));
        vecs.push_back(mk("bltu_not",    ALU_BLTU, 32'hFFFFFFFF, 32'd1, 32'h8, 32'h40, 2'b00, 2'b00, 0,0,1,0,0, 32'd0, 32'd1, 0, 0));
        vecs.push_back(mk("bgeu_taken",  ALU_BGEU, 32'hFFFFFFFF, 32'd1, 32'h10, 32'h80, 2'b00, 2'b00, 0,0,1,0,0, 32'd0, 32'd1, 1, 32'h90));
        vecs.push_back(mk("jalr",        ALU_ADD,  32'h1003, 32'd0, 32'd0, 32'h200, 2'b00, 2'b00, 0,1,0,1,0, 32'h204, 32'd0, 1, 32'h1002));
        vecs.push_back(mk("jal",         ALU_ADD,  32'd0, 32'd0, 32'h40, 32'h200, 2'b00, 2'b00, 1,1,0,1,0, 32'h204, 32'd0, 1, 32'h240));
        vecs.push_back(mk("undef_op",    6'd12,    32'd5, 32'd6, 0, 0, 2'b00, 2'b00, 0,0,0,0,0, 32'd0, 32'd6, 0, 0));
        vecs.push_back(mk("flush_jal",   ALU_ADD,  32'd1, 32'd2, 32'h40, 32'h200, 2'b00, 2'b00, 1,1,0,1,1, 32'd0, 32'd0, 0, 0));
        v = mk("lw_addr", ALU_ADD, 32'h100, 32'd0, 32'd8, 0, 2'b00, 2'b00, 0,1,0,0,0, 32'h108, 32'd0, 0, 0);
        v.mr = 1'b1; v.m2r = 1'b1;
        vecs.push_back(v);
        v = mk("sw_addr", ALU_ADD, 32'h100, 32'hDEAD, 32'd4, 0, 2'b00, FWD_MEM, 0,1,0,0,0, 32'h104, 32'd5, 0, 0);
        v.mw = 1'b1; v.rw = 1'b0;
        vecs.push_back(v);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_result", bus.alu_result_out, 32'd0);
        chk("reset_store", bus.store_data_out, 32'd0);
        chk("reset_ctrl", 32'({bus.rd_addr_out, bus.mem_read_out, bus.mem_write_out,
                               bus.mem_to_reg_out, bus.reg_write_out}), 32'd0);
        chk("reset_busy", 32'(bus.ex_busy), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Vector table
        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            clear_inputs();
            bus.alu_op = v.op; bus.rs1_data = v.rs1; bus.rs2_data = v.rs2; bus.imm = v.imm;
            bus.pc = v.pc; bus.pc_plus4 = v.pc + 32'd4; bus.forward_a_sel = v.fa;
            bus.forward_b_sel = v.fb; bus.alu_src_a = v.sa; bus.alu_src_b = v.sb;
            bus.branch = v.br; bus.jump = v.jmp; bus.flush = v.fl; bus.mem_read = v.mr;
            bus.mem_write = v.mw; bus.mem_to_reg = v.m2r; bus.reg_write = v.rw;
            bus.rd_addr = 5'(i + 1);
            if (v.fl) push_exp(v.name, '0, '0, 9'd0);
            else      push_exp(v.name, v.exp_res, v.exp_store, {5'(i + 1), v.mr, v.mw, v.m2r, v.rw});
            #4;
            chk({v.name, "_taken"}, 32'(bus.branch_taken), 32'(v.exp_taken));
            if (v.exp_taken) chk({v.name, "_target"}, bus.branch_target, v.exp_target);
            tick();
            $display("txn %s result=%h taken=%0d", v.name, bus.alu_result_out, v.exp_taken);
        end

        // Divides
        run_div("div_m7_2",  ALU_DIV,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 1'b1);
        run_div("rem_m7_2",  ALU_REM,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 1'b0);
        run_div("divu_by0",  ALU_DIVU, 32'd9, 32'd0, 32'hFFFFFFFF, 1'b0);
        run_div("remu_by0",  ALU_REMU, 32'd9, 32'd0, 32'd9, 1'b0);
        run_div("rem_m7_0",  ALU_REM,  32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 1'b0);
        run_div("div_ovf",   ALU_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0);
        run_div("rem_ovf",   ALU_REM,  32'h80000000, 32'hFFFFFFFF, 32'd0, 1'b0);
        run_div("div_100_m7", ALU_DIV, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 1'b0);
        run_div("rem_100_m7", ALU_REM, 32'd100, 32'hFFFFFFF9, 32'd2, 1'b0);

        // Flush at RUN count 10 (cycle 11 after the divide enters EX)
        drive_div(ALU_DIV, 32'd100, 32'd7);
        for (int c = 0; c <= 10; c++) begin
            #4;
            chk($sformatf("flushdiv_busy_c%0d", c), 32'(bus.ex_busy), 32'd1);
            push_exp("flushdiv_bubble", '0, '0, 9'd0);
            tick();
        end
        bus.flush = 1'b1;
        #4;
        chk("flushdiv_taken", 32'(bus.branch_taken), 32'd0);
        push_exp("flushdiv_flush", '0, '0, 9'd0);
        tick();
        clear_inputs();
        bus.alu_op = ALU_ADD; bus.rs1_data = 32'd20; bus.rs2_data = 32'd22;
        bus.rd_addr = 5'd4; bus.reg_write = 1'b1;
        #4;
        chk("after_flush_busy", 32'(bus.ex_busy), 32'd0);
        push_exp("after_flush_add", 32'd42, 32'd22, {5'd4, 4'b0001});
        tick();
        clear_inputs();
        #4;
        chk("after_flush_idle_busy", 32'(bus.ex_busy), 32'd0);
        push_exp("after_flush_nop", 32'd0, 32'd0, 9'd0);
        tick();
        $display("txn flush_mid_divide add_result=%h", bus.alu_result_out);

        // Asynchronous reset in the middle of a divide
        drive_div(ALU_DIV, 32'd50, 32'd3);
        for (int c = 0; c <= 5; c++) begin
            #4;
            chk($sformatf("rstdiv_busy_c%0d", c), 32'(bus.ex_busy), 32'd1);
            push_exp("rstdiv_bubble", '0, '0, 9'd0);
            tick();
        end
        clear_inputs();
        #1;
        rst_n = 1'b0;
        #1;
        chk("rstdiv_busy_in_reset", 32'(bus.ex_busy), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        $display("txn reset_mid_divide busy=%0d", bus.ex_busy);
        run_div("divu_after_rst", ALU_DIVU, 32'hFFFFFFFF, 32'd3, 32'h55555555, 1'b0);

        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
